// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags; shifts iterate one bit per cycle.
// Define ALU_PIPE_BARREL_SHIFT_EN to complete shifts in a single cycle instead.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] regA,
    input  logic [WIDTH-1:0] regB,
    input  logic [2:0]       S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] M,
    output logic [3:0]       flags
);

    // state | meaning
    // IDLE  | no result held, ready for an operation
    // SHIFT | iterative shift in progress, one bit per cycle
    // HOLD  | result valid on M/flags until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifndef ALU_PIPE_BARREL_SHIFT_EN
        SHIFT = 2'd1,
`endif
        HOLD  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q;
    logic [WIDTH-1:0] m_q;
    logic [3:0]       flags_q;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;
    logic [3:0]       flags_d;
    logic             accept;

`ifdef ALU_PIPE_BARREL_SHIFT_EN
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
`else
    logic [CW-1:0]    cnt_q;
    logic             dir_q;
    logic             start_shift_d;
    logic [WIDTH-1:0] step_w;
    logic             step_c;
`endif

    assign sum_w  = {1'b0, regA} + {1'b0, regB};
    assign diff_w = {1'b0, regA} - {1'b0, regB};

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
`ifdef ALU_PIPE_BARREL_SHIFT_EN
        shl_w = '0;
        shr_w = '0;
`else
        start_shift_d = 1'b0;
`endif
        case (S)
            3'b000: begin
                res_d = sum_w[WIDTH-1:0];
                c_d   = sum_w[WIDTH];
                v_d   = (regA[WIDTH-1] == regB[WIDTH-1]) && (sum_w[WIDTH-1] != regA[WIDTH-1]);
            end
            3'b001: begin
                res_d = diff_w[WIDTH-1:0];
                c_d   = diff_w[WIDTH];
                v_d   = (regA[WIDTH-1] != regB[WIDTH-1]) && (diff_w[WIDTH-1] != regA[WIDTH-1]);
            end
            3'b010: res_d = regA & regB;
            3'b011: res_d = regA | regB;
            3'b100: res_d = ~regA;
            3'b101: res_d = regA ^ regB;
            3'b110, 3'b111: begin
                // Full regB is the amount: out-of-range amounts never alias into range.
                if (regB == '0) begin
                    res_d = regA;
                end else if (regB >= WIDTH'(WIDTH)) begin
                    res_d = '0;
                end else begin
`ifdef ALU_PIPE_BARREL_SHIFT_EN
                    if (!S[0]) begin
                        shl_w = {1'b0, regA} << regB;
                        res_d = shl_w[WIDTH-1:0];
                        c_d   = shl_w[WIDTH];
                    end else begin
                        shr_w = {regA, 1'b0} >> regB;
                        res_d = shr_w[WIDTH:1];
                        c_d   = shr_w[0];
                    end
`else
                    start_shift_d = 1'b1;
                    res_d         = regA;
`endif
                end
            end
        endcase
        flags_d = {c_d, v_d, res_d[WIDTH-1], ~|res_d};
    end

`ifndef ALU_PIPE_BARREL_SHIFT_EN
    always_comb begin
        step_w = dir_q ? (m_q >> 1) : (m_q << 1);
        step_c = dir_q ? m_q[0] : m_q[WIDTH-1];
    end
`endif

    assign in_ready  = rst_n & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == HOLD);
    assign M         = m_q;
    assign flags     = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            flags_q <= '0;
`ifndef ALU_PIPE_BARREL_SHIFT_EN
            cnt_q   <= '0;
            dir_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
`ifndef ALU_PIPE_BARREL_SHIFT_EN
                SHIFT: begin
                    m_q   <= step_w;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= HOLD;
                        flags_q <= {step_c, 1'b0, step_w[WIDTH-1], ~|step_w};
                    end
                end
`endif
                default: begin
                    if (accept) begin
                        m_q     <= res_d;
                        flags_q <= flags_d;
`ifndef ALU_PIPE_BARREL_SHIFT_EN
                        if (start_shift_d) begin
                            state_q <= SHIFT;
                            cnt_q   <= regB[CW-1:0];
                            dir_q   <= S[0];
                        end else begin
                            state_q <= HOLD;
                        end
`else
                        state_q <= HOLD;
`endif
                    end else if (state_q == HOLD && out_ready) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=8 with hand-computed results.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] regA;
    logic [7:0] regB;
    logic [2:0] S;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] M;
    logic [3:0] flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [3:0] f;
    } vec_t;

    alu_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .regA(regA), .regB(regB), .S(S), .out_valid(out_valid),
        .out_ready(out_ready), .M(M), .flags(flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; regA = '0; regB = '0; S = '0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        checks++; if (M !== 8'h00) begin errors++; $display("FAIL reset_M: got %h exp 00", M); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", flags); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_alu_ops();
        vec_t v [14];
        v = '{
            '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1001},
            '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0110},
            '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0100},
            '{3'b001, 8'h01, 8'h02, 8'hFF, 4'b1010},
            '{3'b001, 8'h05, 8'h05, 8'h00, 4'b0001},
            '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000},
            '{3'b011, 8'h0F, 8'h80, 8'h8F, 4'b0010},
            '{3'b100, 8'h55, 8'h12, 8'hAA, 4'b0010},
            '{3'b101, 8'hAA, 8'hFF, 8'h55, 4'b0000},
            '{3'b101, 8'h3C, 8'h3C, 8'h00, 4'b0001},
            '{3'b110, 8'h81, 8'h00, 8'h81, 4'b0010},
            '{3'b111, 8'h81, 8'h08, 8'h00, 4'b0001},
            '{3'b110, 8'h81, 8'hC8, 8'h00, 4'b0001},
            '{3'b111, 8'hC3, 8'h09, 8'h00, 4'b0001}
        };
        out_ready = 1'b1;
        foreach (v[i]) begin
            in_valid = 1'b1; S = v[i].op; regA = v[i].a; regB = v[i].b;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_out_valid: got %b exp 1", i, out_valid); end
            checks++; if (M !== v[i].m) begin errors++; $display("FAIL op%0d_M: got %h exp %h", i, M, v[i].m); end
            checks++; if (flags !== v[i].f) begin errors++; $display("FAIL op%0d_flags: got %b exp %b", i, flags, v[i].f); end
            @(negedge clk);
        end
    endtask

    task automatic test_iter_shift();
        vec_t v [5];
        int   lat;
        v = '{
            '{3'b110, 8'h81, 8'd3, 8'h08, 4'b0000},
            '{3'b111, 8'h81, 8'd1, 8'h40, 4'b1000},
            '{3'b111, 8'h81, 8'd2, 8'h20, 4'b0000},
            '{3'b110, 8'h03, 8'd7, 8'h80, 4'b1010},
            '{3'b111, 8'hC0, 8'd7, 8'h01, 4'b1000}
        };
        out_ready = 1'b1;
        foreach (v[i]) begin
`ifdef ALU_PIPE_BARREL_SHIFT_EN
            lat = 0;
`else
            lat = int'(v[i].b);
`endif
            in_valid = 1'b1; S = v[i].op; regA = v[i].a; regB = v[i].b;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            for (int k = 0; k < lat; k++) begin
                checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                    errors++; $display("FAIL sh%0d_busy_c%0d: in_ready=%b out_valid=%b exp 0/0", i, k, in_ready, out_valid);
                end
                @(negedge clk);
            end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sh%0d_out_valid: got %b exp 1", i, out_valid); end
            checks++; if (M !== v[i].m) begin errors++; $display("FAIL sh%0d_M: got %h exp %h", i, M, v[i].m); end
            checks++; if (flags !== v[i].f) begin errors++; $display("FAIL sh%0d_flags: got %b exp %b", i, flags, v[i].f); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid = 1'b1; S = 3'b010; regA = 8'hF0; regB = 8'h3C;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            S = 3'b011; regA = 8'h0F; regB = 8'hA0;
            checks++; if (out_valid !== 1'b1 || M !== 8'h30 || flags !== 4'b0000 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_c%0d: ov=%b M=%h flags=%b in_ready=%b exp 1/30/0000/0", k, out_valid, M, flags, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || M !== 8'hAF || flags !== 4'b0010) begin
            errors++; $display("FAIL bp_next_result: ov=%b M=%h flags=%b exp 1/AF/0010", out_valid, M, flags);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        out_ready = 1'b1;
        in_valid = 1'b1; S = 3'b110; regA = 8'h01; regB = 8'd6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (M !== 8'h00 || flags !== 4'h0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_clear: M=%h flags=%b ov=%b in_ready=%b exp 00/0000/0/0", M, flags, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b exp 1", in_ready); end
        in_valid = 1'b1; S = 3'b101; regA = 8'hAA; regB = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || M !== 8'h55 || flags !== 4'b0000) begin
            errors++; $display("FAIL midrst_xor: ov=%b M=%h flags=%b exp 1/55/0000", out_valid, M, flags);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_c%0d: ov=%b exp 0", k, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [4];
        v = '{
            '{3'b000, 8'h10, 8'h20, 8'h30, 4'b0000},
            '{3'b001, 8'h10, 8'h20, 8'hF0, 4'b1010},
            '{3'b011, 8'h01, 8'h02, 8'h03, 4'b0000},
            '{3'b100, 8'hFF, 8'h00, 8'h00, 4'b0001}
        };
        out_ready = 1'b1;
        foreach (v[i]) begin
            in_valid = 1'b1; S = v[i].op; regA = v[i].a; regB = v[i].b;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready: got %b exp 1", i, in_ready); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || M !== v[i].m || flags !== v[i].f) begin
                errors++; $display("FAIL b2b%0d_result: ov=%b M=%h flags=%b exp 1/%h/%b", i, out_valid, M, flags, v[i].m, v[i].f);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: ov=%b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_iter_shift();
        test_back_pressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
